// File: rtl/sp_ebr_pkg.sv
// Shared types and mode constants for the single-port EBR with memory clear.
package sp_ebr_pkg;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_CLR  = 1'b1
  } clrState_e;

  localparam string REGMODE_NOREG            = "NOREG";
  localparam string REGMODE_OUTREG           = "OUTREG";
  localparam string WRITEMODE_NORMAL         = "NORMAL";
  localparam string WRITEMODE_WRITETHROUGH   = "WRITETHROUGH";
  localparam string WRITEMODE_READBEFOREWRITE = "READBEFOREWRITE";

endpackage

// File: rtl/sp_ebr_clr_seq.sv
// Clear sequencer: walks every word address once, issuing zero-writes,
// and reports BUSY for exactly the duration of the walk.
module sp_ebr_clr_seq
  import sp_ebr_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int CLR_ON_RST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  output logic                  clrWe,
  output logic [ADDR_WIDTH-1:0] clrAddr
);

  localparam bit RST_CLEARS = (CLR_ON_RST != 0);

  clrState_e             state;
  clrState_e             nextState;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  lastWord;
  logic                  startClear;

  assign lastWord   = (cnt == {ADDR_WIDTH{1'b1}});
  assign startClear = (state == SEQ_IDLE) && clear;

  // Reset either parks the sequencer or restarts a full clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_CLEARS ? SEQ_CLR : SEQ_IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (startClear) begin
        cnt <= '0;
      end else if ((state == SEQ_CLR) && !lastWord) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      SEQ_IDLE: if (clear)    nextState = SEQ_CLR;
      SEQ_CLR:  if (lastWord) nextState = SEQ_IDLE;
      default:                nextState = SEQ_IDLE;
    endcase
  end

  // The zero-write is suppressed on a reset cycle so an aborted clear
  // leaves the word under the counter untouched.
  always_comb begin
    busy    = (state == SEQ_CLR);
    clrWe   = (state == SEQ_CLR) && !rst;
    clrAddr = cnt;
  end

endmodule

// File: rtl/sp_ebr_clr.sv
// Single-port embedded block RAM with selectable write/read modes, optional
// output register and a hardware memory-clear sequencer.
module sp_ebr_clr
  import sp_ebr_pkg::*;
#(
  parameter int          DATA_WIDTH = 18,
  parameter int          ADDR_WIDTH = 10,
  parameter string       REGMODE    = "NOREG",
  parameter string       WRITEMODE  = "NORMAL",
  parameter logic [2:0]  CSDECODE   = 3'b000,
  parameter int          CLR_ON_RST = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  OCE,
  input  logic                  WE,
  input  logic [2:0]            CS,
  input  logic [ADDR_WIDTH-1:0] AD,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic                  CLEAR,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  BUSY
);

  localparam int DEPTH                = 2 ** ADDR_WIDTH;
  localparam bit IS_OUTREG            = (REGMODE == REGMODE_OUTREG);
  localparam bit IS_WRITETHROUGH      = (WRITEMODE == WRITEMODE_WRITETHROUGH);
  localparam bit IS_READBEFOREWRITE   = (WRITEMODE == WRITEMODE_READBEFOREWRITE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] readLatch;
  logic [DATA_WIDTH-1:0] outReg;
  logic                  busy;
  logic                  clrWe;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic                  en;
  logic                  userWrite;

  sp_ebr_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_seq (
    .clk     (CLK),
    .rst     (RST),
    .clear   (CLEAR),
    .busy    (busy),
    .clrWe   (clrWe),
    .clrAddr (clrAddr)
  );

  assign en        = CE && (CS == CSDECODE) && !busy;
  assign userWrite = en && WE && !RST;

  // The clear port owns the array while busy; user writes are only
  // possible when it is idle, so the two never collide.
  always_ff @(posedge CLK) begin
    if (clrWe) begin
      mem[clrAddr] <= '0;
    end else if (userWrite) begin
      mem[AD] <= DI;
    end
  end

  // Read latch: reads always load, writes load according to the write mode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      readLatch <= '0;
    end else if (en) begin
      if (!WE) begin
        readLatch <= mem[AD];
      end else if (IS_WRITETHROUGH) begin
        readLatch <= DI;
      end else if (IS_READBEFOREWRITE) begin
        readLatch <= mem[AD];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      outReg <= '0;
    end else if (OCE) begin
      outReg <= readLatch;
    end
  end

  assign DO   = IS_OUTREG ? outReg : readLatch;
  assign BUSY = busy;

endmodule

// File: tb/tb_sp_ebr_clr.sv
// Directed bench for sp_ebr_clr: five instances cover the register modes,
// write modes and both reset-clear behaviours from one shared stimulus.
module tb_sp_ebr_clr;

  localparam int DW = 18;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          oce;
  logic          we;
  logic [2:0]    cs;
  logic [AW-1:0] ad;
  logic [DW-1:0] di;
  logic          clear;

  logic [DW-1:0] dout0, dout1, dout2, dout3, dout4;
  logic          busy0, busy1, busy2, busy3, busy4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sp_ebr_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGMODE("NOREG"),
               .WRITEMODE("NORMAL"), .CSDECODE(3'b000), .CLR_ON_RST(0)) u0 (
    .CLK(clk), .RST(rst), .CE(ce), .OCE(oce), .WE(we), .CS(cs), .AD(ad),
    .DI(di), .CLEAR(clear), .DO(dout0), .BUSY(busy0));

  sp_ebr_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGMODE("OUTREG"),
               .WRITEMODE("NORMAL"), .CSDECODE(3'b000), .CLR_ON_RST(0)) u1 (
    .CLK(clk), .RST(rst), .CE(ce), .OCE(oce), .WE(we), .CS(cs), .AD(ad),
    .DI(di), .CLEAR(clear), .DO(dout1), .BUSY(busy1));

  sp_ebr_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGMODE("NOREG"),
               .WRITEMODE("WRITETHROUGH"), .CSDECODE(3'b000), .CLR_ON_RST(0)) u2 (
    .CLK(clk), .RST(rst), .CE(ce), .OCE(oce), .WE(we), .CS(cs), .AD(ad),
    .DI(di), .CLEAR(clear), .DO(dout2), .BUSY(busy2));

  sp_ebr_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGMODE("NOREG"),
               .WRITEMODE("READBEFOREWRITE"), .CSDECODE(3'b000), .CLR_ON_RST(0)) u3 (
    .CLK(clk), .RST(rst), .CE(ce), .OCE(oce), .WE(we), .CS(cs), .AD(ad),
    .DI(di), .CLEAR(clear), .DO(dout3), .BUSY(busy3));

  sp_ebr_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGMODE("NOREG"),
               .WRITEMODE("NORMAL"), .CSDECODE(3'b000), .CLR_ON_RST(1)) u4 (
    .CLK(clk), .RST(rst), .CE(ce), .OCE(oce), .WE(we), .CS(cs), .AD(ad),
    .DI(di), .CLEAR(clear), .DO(dout4), .BUSY(busy4));

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic o,
                               input logic w, input logic [2:0] s,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic clr);
    rst   = r;
    ce    = c;
    oce   = o;
    we    = w;
    cs    = s;
    ad    = a;
    di    = d;
    clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; oce = 1'b0; we = 1'b0;
    cs = 3'b000; ad = '0; di = '0; clear = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("rst_do0", dout0, 18'h0);
    checkOutput("rst_do1", dout1, 18'h0);
    checkOutput("rst_do3", dout3, 18'h0);
    checkOutput("rst_busy0", {17'b0, busy0}, 18'h0);
    checkOutput("rst_busy4", {17'b0, busy4}, 18'h1);
    for (int i = 1; i <= 15; i++) applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("rstclr_busy_last", {17'b0, busy4}, 18'h1);
    applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("rstclr_busy_done", {17'b0, busy4}, 18'h0);

    $display("[TB] normal write / read");
    applyStimulus(0, 1, 1, 1, 3'b000, 4'd3, 18'h2A5A5, 0);
    checkOutput("wr_do_hold", dout0, 18'h0);
    checkOutput("wr_wt", dout2, 18'h2A5A5);
    applyStimulus(0, 1, 1, 0, 3'b000, 4'd3, 18'h0, 0);
    checkOutput("rd_noreg", dout0, 18'h2A5A5);
    checkOutput("rd_outreg_1", dout1, 18'h0);
    applyStimulus(0, 0, 1, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("rd_outreg_2", dout1, 18'h2A5A5);

    $display("[TB] output register enable");
    applyStimulus(0, 1, 0, 1, 3'b000, 4'd4, 18'h15A5A, 0);
    applyStimulus(0, 1, 0, 0, 3'b000, 4'd4, 18'h0, 0);
    checkOutput("rd4_noreg", dout0, 18'h15A5A);
    checkOutput("oce0_hold_a", dout1, 18'h2A5A5);
    applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("oce0_hold_b", dout1, 18'h2A5A5);
    applyStimulus(0, 0, 1, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("oce1_load", dout1, 18'h15A5A);

    $display("[TB] write modes");
    applyStimulus(0, 1, 0, 1, 3'b000, 4'd5, 18'h11111, 0);
    checkOutput("wt_do", dout2, 18'h11111);
    checkOutput("normal_hold", dout0, 18'h15A5A);
    applyStimulus(0, 1, 0, 1, 3'b000, 4'd5, 18'h22222, 0);
    checkOutput("rbw_do", dout3, 18'h11111);
    checkOutput("wt_do2", dout2, 18'h22222);
    applyStimulus(0, 1, 0, 0, 3'b000, 4'd5, 18'h0, 0);
    checkOutput("rbw_after", dout3, 18'h22222);
    checkOutput("rd5_noreg", dout0, 18'h22222);

    $display("[TB] chip select");
    applyStimulus(0, 1, 0, 1, 3'b000, 4'd7, 18'h0ABCD, 0);
    checkOutput("cs_pre_wt", dout2, 18'h0ABCD);
    applyStimulus(0, 1, 0, 1, 3'b001, 4'd7, 18'h3FFFF, 0);
    checkOutput("cs_miss_wt", dout2, 18'h0ABCD);
    checkOutput("cs_miss_do", dout0, 18'h22222);
    applyStimulus(0, 1, 0, 0, 3'b000, 4'd7, 18'h0, 0);
    checkOutput("cs_mem7", dout0, 18'h0ABCD);
    checkOutput("cs_mem7_rbw", dout3, 18'h0ABCD);

    $display("[TB] clear sequence");
    applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 1);
    checkOutput("clr_busy_c0", {17'b0, busy0}, 18'h1);
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) applyStimulus(0, 1, 0, 1, 3'b000, 4'd0, 18'h3FFFF, 1);
      else        applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
      checkOutput($sformatf("clr_busy_c%0d", i), {17'b0, busy0}, 18'h1);
    end
    applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("clr_busy_end", {17'b0, busy0}, 18'h0);
    checkOutput("clr_drop_wt", dout2, 18'h0ABCD);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 0, 0, 3'b000, i[AW-1:0], 18'h0, 0);
      checkOutput($sformatf("clr_rd%0d", i), dout0, 18'h0);
    end

    $display("[TB] reset during clear");
    for (int i = 8; i < 16; i++)
      applyStimulus(0, 1, 0, 1, 3'b000, i[AW-1:0], 18'(32'h100 + i), 0);
    applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 1);
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
    applyStimulus(1, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
    checkOutput("abort_busy0", {17'b0, busy0}, 18'h0);
    checkOutput("abort_do0", dout0, 18'h0);
    checkOutput("restart_busy4", {17'b0, busy4}, 18'h1);
    checkOutput("restart_do4", dout4, 18'h0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 0, 0, 0, 3'b000, 4'd0, 18'h0, 0);
      checkOutput($sformatf("restart_busy_k%0d", k), {17'b0, busy4},
                  (k <= 15) ? 18'h1 : 18'h0);
      checkOutput($sformatf("restart_do_k%0d", k), dout4, 18'h0);
    end
    for (int i = 8; i < 16; i++) begin
      applyStimulus(0, 1, 0, 0, 3'b000, i[AW-1:0], 18'h0, 0);
      checkOutput($sformatf("keep_rd%0d", i), dout0, 18'(32'h100 + i));
      checkOutput($sformatf("reclr_rd%0d", i), dout4, 18'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
